disp_scan: RTL and testbench
============================

DISP_SCAN -- requirements
Module: disp_scan

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 10, meaning the display-memory address width (frame = 2**ADDR_W pixels).
REQ-002 The block SHALL have parameter COL_W, default 5, meaning the column field width; row width = ADDR_W-COL_W.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all logic on posedge.
REQ-004 The block SHALL have port reset, input, 1, a synchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1, a request to begin one frame scan.
REQ-006 The block SHALL have port busy, output, 1, high from accepted start until frame_done.
REQ-007 The block SHALL have port mem_addr, output, ADDR_W, the read address to the 1-bit display memory.
REQ-008 The block SHALL have port mem_wr, output, 1, the memory write enable, tied to 0.
REQ-009 The block SHALL have port mem_d, input, 1, the memory read data, valid one clock edge after mem_addr is presented.
REQ-010 The block SHALL have port pix_valid, output, 1, high when pix_data/pix_row/pix_col hold a pixel.
REQ-011 The block SHALL have port pix_ready, input, 1, sink acceptance; a transfer occurs on an edge with pix_valid&&pix_ready.
REQ-012 The block SHALL have ports pix_data (1), pix_row (ADDR_W-COL_W) and pix_col (COL_W), outputs carrying the pixel value and its coordinates.
REQ-013 The block SHALL have port frame_done, output, 1, a one-cycle pulse after the last pixel transfers.

Function
REQ-014 The FSM SHALL have states IDLE, SCAN and DRAIN; busy SHALL be 1 in SCAN and DRAIN.
- IDLE -> SCAN: start=1; next read address := 0.
- SCAN -> DRAIN: read of address 2**ADDR_W-1 issued.
- DRAIN -> IDLE: last pixel transferred; frame_done=1 for exactly that next cycle.
REQ-015 In states other than IDLE, start SHALL be ignored.
REQ-016 Reads SHALL be issued in ascending address order 0..2**ADDR_W-1, one per cycle at most, with no gaps or repeats.
REQ-017 A read SHALL be issued only when (buffered pixels + reads in flight) < 2, so that no returned data is ever dropped.
REQ-018 Returned data SHALL enter a 2-entry FIFO tagged with its address; the FIFO head drives pix_data, pix_row=addr[ADDR_W-1:COL_W] and pix_col=addr[COL_W-1:0].
REQ-019 While pix_valid=1 and pix_ready=0, the pix_* outputs SHALL hold stable.
REQ-020 A simultaneous push and pop on the FIFO SHALL keep occupancy unchanged and preserve order.
REQ-021 With pix_ready held at 1, throughput SHALL be 1 pixel/cycle once the pipeline fills; the first pix_valid SHALL rise at most 3 cycles after start.
REQ-022 A full frame with pix_ready held at 1 SHALL complete, start to frame_done, in 2**ADDR_W + 3 cycles or fewer.
REQ-023 The address counter SHALL NOT wrap within a frame; after the last read, mem_addr SHALL hold its value until IDLE.
REQ-024 In IDLE, mem_addr SHALL be 0 and pix_valid SHALL be 0.

Reset
REQ-025 On reset=1 at a clock edge, the block SHALL enter IDLE with busy=0, pix_valid=0, frame_done=0, mem_addr=0, pix_data=0, pix_row=0, pix_col=0, and FIFO empty.
REQ-026 A reset asserted mid-frame SHALL discard in-flight reads and buffered pixels; data returning after reset SHALL be ignored.
REQ-027 The block SHALL require a fresh start after reset.

Verification
REQ-028 The bench SHALL cover: memory preloaded mem[k]=k[0]^k[5], start pulse, pix_ready=1 -> 1024 transfers with pix_row=k>>5, pix_col=k&31, data correct, frame_done once, total ≤1027 cycles.
REQ-029 The bench SHALL cover: random pix_ready at 30% duty -> same ordered 1024 pixels, outputs stable during stalls, no loss or duplication.
REQ-030 The bench SHALL cover: pix_ready=0 for 20 cycles after start -> at most 2 reads issued; pix_valid=1 with pixel (0,0) held throughout.
REQ-031 The bench SHALL cover: start re-pulsed at pixel 500 -> ignored; scan continues and frame_done occurs exactly once.
REQ-032 The bench SHALL cover: reset at pixel 300 -> next cycle busy=0, pix_valid=0; a new start rescans from (0,0).
REQ-033 The bench SHALL cover: frame end with pix_ready toggling -> pixel (31,31) is last and frame_done is asserted in the cycle after its transfer; mem_wr=0 throughout all scenarios.

Source files
------------

// File: rtl/disp_scan.sv
// Raster scanner: reads a 1-bit display memory in address order and streams (row, col, pixel) with valid/ready.
// Two-cycle read-to-valid latency; reads are throttled so the 2-entry buffer never overflows under sink stalls.
module disp_scan #(
    parameter int ADDR_W = 10,
    parameter int COL_W  = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    output logic                    busy,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic                    mem_wr,
    input  logic                    mem_d,
    output logic                    pix_valid,
    input  logic                    pix_ready,
    output logic                    pix_data,
    output logic [ADDR_W-COL_W-1:0] pix_row,
    output logic [COL_W-1:0]        pix_col,
    output logic                    frame_done
);

    localparam logic [ADDR_W-1:0] LAST = '1;

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] rd_addr;
    logic              fly;
    logic [ADDR_W-1:0] fly_addr;
    logic              ent_d [2];
    logic [ADDR_W-1:0] ent_a [2];
    logic              rd_ptr, wr_ptr;
    logic [1:0]        count;
    logic [1:0]        occ;
    logic              issue, push, pop, frame_end;
    logic [ADDR_W-1:0] head_addr;

    assign head_addr = ent_a[rd_ptr];
    assign pix_valid = (count != 2'd0);
    assign pix_data  = ent_d[rd_ptr];
    assign pix_row   = head_addr[ADDR_W-1:COL_W];
    assign pix_col   = head_addr[COL_W-1:0];
    assign mem_addr  = rd_addr;
    assign mem_wr    = 1'b0;
    assign busy      = (state != IDLE);
    assign pop       = pix_valid && pix_ready;
    assign push      = fly;

    // Occupancy after this cycle's pop plus the read still in flight; keeps 1 pixel/cycle when the sink is ready.
    assign occ   = count - 2'(pop) + 2'(fly);
    assign issue = (state == SCAN) && (occ < 2'd2);

    always_comb begin
        state_nx  = state;
        frame_end = 1'b0;
        case (state)
            IDLE:  if (start) state_nx = SCAN;
            SCAN:  if (issue && rd_addr == LAST) state_nx = DRAIN;
            DRAIN: if (pop && head_addr == LAST) begin
                state_nx  = IDLE;
                frame_end = 1'b1;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            rd_addr    <= '0;
            fly        <= 1'b0;
            fly_addr   <= '0;
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
            count      <= 2'd0;
            frame_done <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                ent_d[i] <= 1'b0;
                ent_a[i] <= '0;
            end
        end else begin
            state      <= state_nx;
            frame_done <= frame_end;
            fly        <= issue;
            if (issue)
                fly_addr <= rd_addr;
            // Counter parks on the last address until the frame ends, then returns to 0.
            if (state_nx == IDLE)
                rd_addr <= '0;
            else if (issue && rd_addr != LAST)
                rd_addr <= rd_addr + ADDR_W'(1);
            if (push) begin
                ent_d[wr_ptr] <= mem_d;
                ent_a[wr_ptr] <= fly_addr;
                wr_ptr        <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_disp_scan.sv
// Scoreboard bench for disp_scan: expected pixel stream queued per frame, popped on each transfer.
module tb_disp_scan;

    logic       clk = 1'b0;
    logic       reset, start, busy, mem_wr, mem_d, pix_valid, pix_ready, pix_data, frame_done;
    logic [9:0] mem_addr;
    logic [4:0] pix_row, pix_col;

    logic        mem [1024];
    logic [10:0] exp_q[$];
    int          checks = 0;
    int          passed = 0;

    disp_scan #(.ADDR_W(10), .COL_W(5)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy),
        .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_d(mem_d),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
        .pix_row(pix_row), .pix_col(pix_col), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) mem_d <= mem[mem_addr];

    task automatic fill_queue();
        logic [9:0] k;
        exp_q.delete();
        for (int i = 0; i < 1024; i++) begin
            k = 10'(i);
            exp_q.push_back({k[0] ^ k[5], k});
        end
    endtask

    // One frame: drives pix_ready (duty 0..100 %, or -1 for toggling), optional mid-frame start (ev_kind 1) or reset (ev_kind 2).
    task automatic scan(input bit do_start, input int duty, input int ev_pix, input int ev_kind,
                        input string tag, output int cycles, output int first_vld);
        int          cyc = 0, ndone = 0, nxfer = 0, stall_bad = 0, wr_bad = 0, after = 0;
        int          last_k = -1, last_x = -10;
        bit          prev_stall = 0, ev_done = 0, tog = 0;
        logic [10:0] prev_out = '0, ex;
        cycles = -1;
        first_vld = -1;
        if (do_start) begin
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        while (cyc < 9000) begin
            if (mem_wr !== 1'b0) wr_bad++;
            if (pix_valid === 1'b1 && first_vld < 0) first_vld = cyc;
            if (frame_done === 1'b1) begin
                ndone++;
                if (ndone == 1) begin
                    cycles = cyc;
                    checks++;
                    if (last_k == 1023 && last_x + 1 == cyc) passed++;
                    else $display("FAIL %s done_timing: last pixel %0d decided at %0d, frame_done at %0d; required pixel 1023 on preceding edge",
                                  tag, last_k, last_x, cyc);
                end
            end
            if (prev_stall && {pix_valid, pix_data, pix_row, pix_col} !== {1'b1, prev_out}) stall_bad++;
            if (ndone > 0) begin
                if (after == 3) break;
                after++;
            end
            if (duty < 0) begin
                tog = !tog;
                pix_ready = tog;
            end else begin
                pix_ready = (int'($urandom_range(0, 99)) < duty);
            end
            if (ev_kind == 2 && nxfer == ev_pix) begin
                pix_ready = 1'b0;
                reset = 1'b1;
                @(posedge clk); #1;
                reset = 1'b0;
                checks++;
                if (busy === 1'b0 && pix_valid === 1'b0 && mem_addr === 10'd0 && frame_done === 1'b0) passed++;
                else $display("FAIL %s reset_outputs: busy=%b pix_valid=%b mem_addr=%0d frame_done=%b, required 0 0 0 0",
                              tag, busy, pix_valid, mem_addr, frame_done);
                repeat (3) @(posedge clk);
                #1;
                checks++;
                if (busy === 1'b0 && pix_valid === 1'b0) passed++;
                else $display("FAIL %s post_reset_idle: busy=%b pix_valid=%b, required 0 0", tag, busy, pix_valid);
                exp_q.delete();
                return;
            end
            if (ev_kind == 1 && nxfer == ev_pix && !ev_done) begin
                start = 1'b1;
                ev_done = 1;
            end else begin
                start = 1'b0;
            end
            if (pix_valid === 1'b1 && pix_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL %s extra_pixel: got (%0d,%0d), required none", tag, pix_row, pix_col);
                end else begin
                    ex = exp_q.pop_front();
                    if ({pix_data, pix_row, pix_col} === ex) passed++;
                    else $display("FAIL %s pixel %0d: got data=%b row=%0d col=%0d, required data=%b row=%0d col=%0d",
                                  tag, nxfer, pix_data, pix_row, pix_col, ex[10], ex[9:5], ex[4:0]);
                end
                nxfer++;
                last_k = int'({pix_row, pix_col});
                last_x = cyc;
            end
            prev_stall = (pix_valid === 1'b1 && !pix_ready);
            prev_out = {pix_data, pix_row, pix_col};
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        pix_ready = 1'b0;
        checks++;
        if (ndone == 1) passed++;
        else $display("FAIL %s frame_done_count: got %0d, required 1", tag, ndone);
        checks++;
        if (nxfer == 1024 && exp_q.size() == 0) passed++;
        else $display("FAIL %s transfer_count: got %0d with %0d left, required 1024 with 0 left", tag, nxfer, exp_q.size());
        checks++;
        if (stall_bad == 0) passed++;
        else $display("FAIL %s stall_stability: got %0d unstable cycles, required 0", tag, stall_bad);
        checks++;
        if (wr_bad == 0) passed++;
        else $display("FAIL %s mem_wr: got %0d cycles with mem_wr!=0, required 0", tag, wr_bad);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        pix_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, pix_valid, frame_done, mem_addr, pix_data, pix_row, pix_col} === 24'd0) passed++;
        else $display("FAIL reset_state: busy=%b vld=%b done=%b addr=%0d data=%b row=%0d col=%0d, required all 0",
                      busy, pix_valid, frame_done, mem_addr, pix_data, pix_row, pix_col);
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (busy === 1'b0 && pix_valid === 1'b0 && mem_addr === 10'd0) passed++;
        else $display("FAIL idle_without_start: busy=%b pix_valid=%b mem_addr=%0d, required 0 0 0", busy, pix_valid, mem_addr);
    endtask

    task automatic test_full_frame();
        int cyc, fv;
        fill_queue();
        scan(1, 100, -1, 0, "full", cyc, fv);
        checks++;
        if (cyc >= 0 && cyc <= 1027) passed++;
        else $display("FAIL full frame_latency: got %0d cycles, required <= 1027", cyc);
        checks++;
        if (fv >= 0 && fv <= 3) passed++;
        else $display("FAIL full first_valid: got cycle %0d, required <= 3", fv);
    endtask

    task automatic test_random_ready();
        int cyc, fv;
        fill_queue();
        scan(1, 30, -1, 0, "random30", cyc, fv);
    endtask

    task automatic test_stall_start();
        int cyc, fv, bad = 0, addr_bad = 0;
        fill_queue();
        pix_ready = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (mem_addr > 10'd2) addr_bad++;
            if (i >= 3 && {pix_valid, pix_data, pix_row, pix_col} !== 12'b1_0_00000_00000) bad++;
        end
        checks++;
        if (addr_bad == 0) passed++;
        else $display("FAIL stall read_limit: mem_addr=%0d in %0d cycles, required <= 2", mem_addr, addr_bad);
        checks++;
        if (bad == 0) passed++;
        else $display("FAIL stall hold_pixel00: got %0d bad cycles, required 0", bad);
        scan(0, 100, -1, 0, "stall_rest", cyc, fv);
    endtask

    task automatic test_restart_ignored();
        int cyc, fv;
        fill_queue();
        scan(1, 100, 500, 1, "restart", cyc, fv);
    endtask

    task automatic test_mid_reset();
        int cyc, fv;
        fill_queue();
        scan(1, 100, 300, 2, "reset300", cyc, fv);
        fill_queue();
        scan(1, 100, -1, 0, "rescan", cyc, fv);
    endtask

    task automatic test_frame_end_toggle();
        int cyc, fv;
        fill_queue();
        scan(1, -1, -1, 0, "toggle", cyc, fv);
    endtask

    initial begin
        logic [9:0] k;
        for (int i = 0; i < 1024; i++) begin
            k = 10'(i);
            mem[i] = k[0] ^ k[5];
        end
        reset = 1'b1;
        start = 1'b0;
        pix_ready = 1'b0;
        test_reset();
        test_full_frame();
        test_random_ready();
        test_stall_start();
        test_restart_ignored();
        test_mid_reset();
        test_frame_end_toggle();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
